// File: rtl/cache_wb_ctrl.sv
// cache_wb_ctrl
//   Write-back, write-allocate controller for a 4-line x 4-word direct-mapped
//   data cache. Owns tag/valid/dirty state and the 16-word data array, and
//   turns a CPU request/ready handshake into line-granular memory transactions.
//   A dirty victim is always written back before the refill.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cpu_req               CPU request, sampled only in IDLE
//   i_cpu_write             1 = store, 0 = load
//   i_cpu_address[9:0]      byte address: tag [9:6], index [5:4], word [3:2]
//   i_cpu_write_data[31:0]  store data
//   o_cpu_read_data[31:0]   load data, held until the next completed load
//   o_cpu_ready             one-cycle completion pulse
//   o_cpu_hit               request hit on first lookup (valid with o_cpu_ready)
//   o_mem_req               memory transaction request
//   o_mem_write             1 = line write-back, 0 = line fetch
//   o_mem_address[9:0]      line byte address, bits [3:0] zero
//   o_mem_write_data[127:0] victim line, word0 in [127:96]
//   i_mem_read_data[127:0]  refill line, same ordering
//   i_mem_ready             memory completion, meaningful only with o_mem_req

module cache_wb_ctrl (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_cpu_req,
    input  logic         i_cpu_write,
    input  logic [9:0]   i_cpu_address,
    input  logic [31:0]  i_cpu_write_data,
    output logic [31:0]  o_cpu_read_data,
    output logic         o_cpu_ready,
    output logic         o_cpu_hit,
    output logic         o_mem_req,
    output logic         o_mem_write,
    output logic [9:0]   o_mem_address,
    output logic [127:0] o_mem_write_data,
    input  logic [127:0] i_mem_read_data,
    input  logic         i_mem_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate,
        StDone
    } state_t;

    state_t       r_state;
    state_t       w_state_d;

    logic [3:0]   r_valid;
    logic [3:0]   r_dirty;
    logic [3:0]   r_tag  [4];
    logic [31:0]  r_data [16];

    // Latched request; byte-offset bits are never needed
    logic         r_req_write;
    logic [9:2]   r_req_addr;
    logic [31:0]  r_req_wdata;
    logic         r_miss;
    logic [31:0]  r_read_data;
    logic         r_hit;

    logic [3:0]   w_tag;
    logic [1:0]   w_index;
    logic [1:0]   w_word;
    logic         w_line_hit;
    logic         w_store_hit;
    logic         w_refill;
    logic [127:0] w_victim;
    logic         w_unused_addr_bits;

    assign w_unused_addr_bits = ^i_cpu_address[1:0];

    assign w_tag      = r_req_addr[9:6];
    assign w_index    = r_req_addr[5:4];
    assign w_word     = r_req_addr[3:2];
    assign w_line_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign w_store_hit = (r_state == StCompare) && w_line_hit && r_req_write;
    assign w_refill    = (r_state == StAllocate) && i_mem_ready;

    assign w_victim = {r_data[{w_index, 2'd0}], r_data[{w_index, 2'd1}],
                       r_data[{w_index, 2'd2}], r_data[{w_index, 2'd3}]};

    // Next state and memory-side outputs; all mem_* are zero outside a transaction
    always_comb begin
        w_state_d        = r_state;
        o_cpu_ready      = 1'b0;
        o_mem_req        = 1'b0;
        o_mem_write      = 1'b0;
        o_mem_address    = 10'd0;
        o_mem_write_data = 128'd0;
        case (r_state)
            StIdle: begin
                if (i_cpu_req) begin
                    w_state_d = StCompare;
                end
            end
            StCompare: begin
                if (w_line_hit) begin
                    w_state_d = StDone;
                end else if (r_valid[w_index] && r_dirty[w_index]) begin
                    w_state_d = StWriteback;
                end else begin
                    w_state_d = StAllocate;
                end
            end
            StWriteback: begin
                o_mem_req        = 1'b1;
                o_mem_write      = 1'b1;
                o_mem_address    = {r_tag[w_index], w_index, 4'b0000};
                o_mem_write_data = w_victim;
                if (i_mem_ready) begin
                    w_state_d = StAllocate;
                end
            end
            StAllocate: begin
                o_mem_req     = 1'b1;
                o_mem_address = {w_tag, w_index, 4'b0000};
                if (i_mem_ready) begin
                    w_state_d = StCompare;
                end
            end
            StDone: begin
                o_cpu_ready = 1'b1;
                w_state_d   = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Control state, line metadata and CPU-side registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_valid     <= 4'd0;
            r_dirty     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_tag[i] <= 4'd0;
            end
            r_req_write <= 1'b0;
            r_req_addr  <= 8'd0;
            r_req_wdata <= 32'd0;
            r_miss      <= 1'b0;
            r_read_data <= 32'd0;
            r_hit       <= 1'b0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                StIdle: begin
                    if (i_cpu_req) begin
                        r_req_write <= i_cpu_write;
                        r_req_addr  <= i_cpu_address[9:2];
                        r_req_wdata <= i_cpu_write_data;
                        r_miss      <= 1'b0;
                    end
                end
                StCompare: begin
                    if (w_line_hit) begin
                        if (r_req_write) begin
                            r_dirty[w_index] <= 1'b1;
                        end else begin
                            r_read_data <= r_data[{w_index, w_word}];
                        end
                        // A retry after refill always hits, so r_miss reports the first lookup
                        r_hit <= ~r_miss;
                    end else begin
                        r_miss <= 1'b1;
                    end
                end
                StWriteback: begin
                    if (i_mem_ready) begin
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                StAllocate: begin
                    if (i_mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_tag[w_index]   <= w_tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Data array is not reset, but a reset cycle must not commit a line update
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (w_store_hit) begin
                r_data[{w_index, w_word}] <= r_req_wdata;
            end else if (w_refill) begin
                r_data[{w_index, 2'd0}] <= i_mem_read_data[127:96];
                r_data[{w_index, 2'd1}] <= i_mem_read_data[95:64];
                r_data[{w_index, 2'd2}] <= i_mem_read_data[63:32];
                r_data[{w_index, 2'd3}] <= i_mem_read_data[31:0];
            end
        end
    end

    assign o_cpu_read_data = r_read_data;
    assign o_cpu_hit       = r_hit;

endmodule

// File: doc/cache_wb_ctrl.md
# cache_wb_ctrl

Sequenced write-back, write-allocate controller for the 4-line × 4-word direct-mapped data cache. It owns the tag, valid and dirty state and the 16-word data array. It turns a CPU request/ready handshake into line-granular memory transactions, doing a write-back of a dirty victim before every refill. It sits between the CPU load/store stage and the 128-bit line memory, and replaces the purely combinational cache access with a clocked FSM that tolerates any memory latency.

## Interface
- No parameters. Geometry is fixed:
  - 10-bit byte address: tag [9:6], index [5:4], word [3:2]; bits [1:0] are ignored.
  - 4 lines, 32-bit words, 128-bit memory lines.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU request; sampled only in IDLE
- cpu_write  in  1  1 = store, 0 = load
- cpu_address  in  10  byte address
- cpu_write_data  in  32  store data
- cpu_read_data  out  32  load data; held until the next completed load
- cpu_ready  out  1  completion pulse, exactly one cycle per request
- cpu_hit  out  1  1 if the request hit on first lookup; valid while cpu_ready=1
- mem_req  out  1  memory transaction request
- mem_write  out  1  1 = line write-back, 0 = line fetch
- mem_address  out  10  line byte address; bits [3:0] always 0
- mem_write_data  out  128  victim line during write-back; word0 in [127:96], word3 in [31:0]
- mem_read_data  in  128  refill line, same word ordering
- mem_ready  in  1  memory completion; meaningful only while mem_req=1

## Operation
- Per-line state: V, D, 4-bit tag.
- In IDLE with cpu_req=1, the controller latches cpu_write, cpu_address and cpu_write_data, clears the miss flag, and goes to COMPARE.
- cpu_* inputs are ignored in every other state.
- **COMPARE**, hit (V=1 and tag matches):
  - Load: cpu_read_data ← the addressed word.
  - Store: the addressed word ← latched data, and D=1.
  - cpu_hit ← NOT miss flag. Next state DONE.
- **COMPARE**, miss: set the miss flag.
  - V=1 and D=1 → WRITEBACK.
  - Otherwise → ALLOCATE.
- **WRITEBACK**:
  - mem_req=1, mem_write=1.
  - mem_address={stored tag, index, 4'b0}; mem_write_data = the victim line.
  - On mem_ready: D=0, next state ALLOCATE.
- **ALLOCATE**:
  - mem_req=1, mem_write=0.
  - mem_address={latched tag, index, 4'b0}.
  - On mem_ready: line ← mem_read_data, V=1, D=0, tag ← latched tag, next state COMPARE. The retry always hits.
- **DONE**: cpu_ready=1 for this single cycle, then IDLE.
- Outputs when mem_req=0 (IDLE, COMPARE, DONE): mem_write=0, mem_address=0, mem_write_data=0.
- Store misses are write-allocate. The store is completed in the retry COMPARE, so the line ends with D=1 and cpu_hit=0.

## Timing
- Reset values:
  - State IDLE; all V=0, D=0, tags=0.
  - cpu_read_data=0, cpu_ready=0, cpu_hit=0.
  - mem_req=0, mem_write=0, mem_address=0, mem_write_data=0.
  - The data array need not be cleared.
- Hit latency: request sampled in cycle 0 (IDLE) → COMPARE in cycle 1 → cpu_ready=1 in cycle 2 → IDLE in cycle 3.
- Clean miss latency: 2 + A + 2 cycles, where A is the number of ALLOCATE cycles including the mem_ready cycle.
- Dirty miss: adds W WRITEBACK cycles.
- Requester handshake:
  - Hold cpu_req and all cpu_* inputs stable until it sees cpu_ready.
  - Drop cpu_req at the edge that ends the cpu_ready cycle.
  - cpu_req=1 in cycle 3 is treated as a new request.
- Memory handshake:
  - mem_req and all mem_* outputs are stable from the first cycle of WRITEBACK/ALLOCATE through the cycle in which mem_ready=1.
  - mem_req is low, or the next transaction starts, in the following cycle.
  - mem_ready=1 while mem_req=0 is ignored.
  - mem_ready may already be high in the first request cycle, giving 1-cycle transactions.
- A WRITEBACK→ALLOCATE transition keeps mem_req=1 with no gap, and changes mem_write and mem_address on that edge.
- Reset asserted mid-transaction:
  - The next cycle shows the reset values; the partial transaction is abandoned.
  - No line is updated and no cpu_ready is issued.

## Test plan
- **Cold load miss.**
  - Stimulus: after reset, load 0x024; memory returns 128'h11111111_22222222_33333333_44444444 with mem_ready in the 3rd ALLOCATE cycle.
  - Required: a single fetch with mem_address=0x020, mem_write=0, and no write-back; cpu_read_data=0x22222222, cpu_hit=0.
- **Load hit.**
  - Stimulus: then load 0x028.
  - Required: cpu_ready exactly 2 cycles after the accept cycle; cpu_read_data=0x33333333, cpu_hit=1; mem_req never rises.
- **Dirty victim write-back.**
  - Stimulus: store 0xDEADBEEF to 0x02C (hit, cpu_hit=1), then load 0x06C.
  - Required, in order:
    - WRITEBACK with mem_address=0x020 and mem_write_data=128'h11111111_22222222_33333333_DEADBEEF.
    - Then ALLOCATE with mem_address=0x060.
    - cpu_hit=0.
- **Store miss to an invalid line.**
  - Stimulus: store 0xCAFEF00D to 0x104.
  - Required: only a fetch of 0x100, cpu_hit=0.
  - Follow-up: a load of 0x104 hits and returns 0xCAFEF00D.
  - Follow-up: a load of 0x204 then writes back line 0x100 with word1 = 0xCAFEF00D.
- **Stalled memory.**
  - Stimulus: hold mem_ready=0 for 10 cycles in ALLOCATE while toggling cpu_req, cpu_address and cpu_write_data.
  - Required: mem_* outputs constant, cpu_ready=0; the result matches the originally latched request.
- **Reset mid-refill.**
  - Stimulus: assert reset for 1 cycle during ALLOCATE.
  - Required: mem_req=0 and cpu_ready=0 the next cycle; a subsequent load of the same address misses and refetches.
